// File: rtl/game_pkg.sv
// Shared constants, FSM state type and a width helper for the sprite draw scheduler.
package game_pkg;

   localparam int                  X_W          = 8;
   localparam int                  Y_W          = 7;
   localparam int                  COLOUR_W     = 3;
   localparam int                  DEFAULT_SIZE = 4;
   localparam logic [COLOUR_W-1:0] BG_COLOUR    = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_ERASE,
      ST_DRAW,
      ST_DONE
   } sched_state_t;

   // An index into n requesters needs at least one bit even when n is 1.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sprite_draw_scheduler_rr_pick.sv
// Round-robin picker: first set pending bit strictly after i_rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
   import game_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_pending,
   input  logic [IDX_W-1:0]   i_rr_ptr,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_valid
);

   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      // Walk from the farthest candidate to the nearest so the nearest hit is the last write.
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (i_pending[(int'(i_rr_ptr) + k) % NUM_REQ]) begin
            o_idx   = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Frame-paced round-robin sprite plotter sharing one VGA plot port between requesters.
// Build option SPRITE_SCHED_ERASE_EN: erase each sprite's previous square before redrawing it.
//
// state     | meaning
// ST_IDLE   | wait for frame_tick with at least one request, then snapshot req
// ST_SELECT | pick next pending requester round-robin, or return to idle
// ST_ERASE  | plot previous square in background colour
// ST_DRAW   | plot square at latched new position and colour
// ST_DONE   | ack requester, record its position, retire its pending bit
module sprite_draw_scheduler
   import game_pkg::*;
#(
   parameter int                  NUM_REQ   = 4,
   parameter int                  SIZE      = DEFAULT_SIZE,
   parameter logic [COLOUR_W-1:0] BG_COLOUR = game_pkg::BG_COLOUR
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        frame_tick,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*X_W-1:0]      req_x,
   input  logic [NUM_REQ*Y_W-1:0]      req_y,
   input  logic [NUM_REQ*COLOUR_W-1:0] req_colour,
   output logic [NUM_REQ-1:0]          ack,
   output logic                        plot,
   output logic [X_W-1:0]              plot_x,
   output logic [Y_W-1:0]              plot_y,
   output logic [COLOUR_W-1:0]         plot_colour,
   output logic                        busy,
   output logic                        frame_overrun
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int CW    = $clog2(SIZE);
   localparam int PIX_W = 2 * CW;

   sched_state_t        r_state, w_state_nxt;
   logic [NUM_REQ-1:0]  r_pending;
   logic [IDX_W-1:0]    r_rr_ptr, r_idx, w_pick_idx, w_idx_nxt;
   logic                w_pick_valid, w_pix_last, w_start, w_plot_nxt;
   logic [PIX_W-1:0]    r_pix, w_pix_nxt;
   logic [X_W-1:0]      r_new_x, w_new_x_nxt, w_base_x, w_plot_x_nxt;
   logic [Y_W-1:0]      r_new_y, w_new_y_nxt, w_base_y, w_plot_y_nxt;
   logic [COLOUR_W-1:0] r_new_colour, w_new_colour_nxt, w_plot_colour_nxt;
   logic [NUM_REQ-1:0]  w_ack_nxt;
`ifdef SPRITE_SCHED_ERASE_EN
   logic [X_W-1:0]      r_prev_x [NUM_REQ];
   logic [Y_W-1:0]      r_prev_y [NUM_REQ];
   logic [NUM_REQ-1:0]  r_prev_valid;
`endif

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .i_pending (r_pending),
      .i_rr_ptr  (r_rr_ptr),
      .o_idx     (w_pick_idx),
      .o_valid   (w_pick_valid)
   );

   assign w_start       = frame_tick && (req != '0);
   assign w_pix_last    = &r_pix;
   assign frame_overrun = frame_tick && (r_state != ST_IDLE);

   // Requester data is captured in SELECT; later changes on req_* do not affect the service.
   assign w_idx_nxt        = (r_state == ST_SELECT) ? w_pick_idx : r_idx;
   assign w_new_x_nxt      = (r_state == ST_SELECT) ? req_x[w_pick_idx*X_W +: X_W] : r_new_x;
   assign w_new_y_nxt      = (r_state == ST_SELECT) ? req_y[w_pick_idx*Y_W +: Y_W] : r_new_y;
   assign w_new_colour_nxt = (r_state == ST_SELECT) ? req_colour[w_pick_idx*COLOUR_W +: COLOUR_W]
                                                    : r_new_colour;

   always_ff @(posedge clock) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_start) w_state_nxt = ST_SELECT;
         ST_SELECT: begin
            if (!w_pick_valid) w_state_nxt = ST_IDLE;
`ifdef SPRITE_SCHED_ERASE_EN
            else w_state_nxt = r_prev_valid[w_pick_idx] ? ST_ERASE : ST_DRAW;
`else
            else w_state_nxt = ST_DRAW;
`endif
         end
         ST_ERASE:  if (w_pix_last) w_state_nxt = ST_DRAW;
         ST_DRAW:   if (w_pix_last) w_state_nxt = ST_DONE;
         ST_DONE:   w_state_nxt = ST_SELECT;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Pixel index: low CW bits are cx, high CW bits are cy; wraps to 0 between passes.
   always_comb begin
      w_pix_nxt = r_pix;
      if (r_state == ST_SELECT)
         w_pix_nxt = '0;
      else if ((r_state == ST_ERASE) || (r_state == ST_DRAW))
         w_pix_nxt = r_pix + PIX_W'(1);
   end

   // Outputs are computed from next-state values so the registered port lines up with the state.
   always_comb begin
      w_plot_nxt        = (w_state_nxt == ST_ERASE) || (w_state_nxt == ST_DRAW);
      w_base_x          = w_new_x_nxt;
      w_base_y          = w_new_y_nxt;
      w_plot_colour_nxt = w_new_colour_nxt;
`ifdef SPRITE_SCHED_ERASE_EN
      if (w_state_nxt == ST_ERASE) begin
         w_base_x = r_prev_x[w_idx_nxt];
         w_base_y = r_prev_y[w_idx_nxt];
      end
`endif
      if (w_state_nxt == ST_ERASE) w_plot_colour_nxt = BG_COLOUR;
      w_plot_x_nxt = w_base_x + X_W'(w_pix_nxt[CW-1:0]);
      w_plot_y_nxt = w_base_y + Y_W'(w_pix_nxt[PIX_W-1:CW]);
      w_ack_nxt    = '0;
      if (w_state_nxt == ST_DONE) w_ack_nxt[w_idx_nxt] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         plot        <= 1'b0;
         plot_x      <= '0;
         plot_y      <= '0;
         plot_colour <= '0;
         ack         <= '0;
         busy        <= 1'b0;
      end else begin
         plot        <= w_plot_nxt;
         plot_x      <= w_plot_x_nxt;
         plot_y      <= w_plot_y_nxt;
         plot_colour <= w_plot_colour_nxt;
         ack         <= w_ack_nxt;
         busy        <= (w_state_nxt != ST_IDLE);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_pending    <= '0;
         r_rr_ptr     <= IDX_W'(NUM_REQ - 1);
         r_idx        <= '0;
         r_pix        <= '0;
         r_new_x      <= '0;
         r_new_y      <= '0;
         r_new_colour <= '0;
`ifdef SPRITE_SCHED_ERASE_EN
         r_prev_valid <= '0;
`endif
      end else begin
         r_idx        <= w_idx_nxt;
         r_pix        <= w_pix_nxt;
         r_new_x      <= w_new_x_nxt;
         r_new_y      <= w_new_y_nxt;
         r_new_colour <= w_new_colour_nxt;
         if ((r_state == ST_IDLE) && w_start) r_pending <= req;
         if (r_state == ST_DONE) begin
            r_pending[r_idx] <= 1'b0;
            r_rr_ptr         <= r_idx;
`ifdef SPRITE_SCHED_ERASE_EN
            r_prev_valid[r_idx] <= 1'b1;
`endif
         end
      end
   end

`ifdef SPRITE_SCHED_ERASE_EN
   always_ff @(posedge clock) begin
      if (reset && (r_state == ST_DONE)) begin
         r_prev_x[r_idx] <= r_new_x;
         r_prev_y[r_idx] <= r_new_y;
      end
   end
`endif

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: directed and random frames checked against a queue-based reference model.
module tb_sprite_draw_scheduler;

   localparam int         NR   = 4;
   localparam int         SZ   = 4;
   localparam logic [2:0] BG   = 3'b000;
`ifdef SPRITE_SCHED_ERASE_EN
   localparam bit         ERASE = 1'b1;
`else
   localparam bit         ERASE = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset;
   logic             frame_tick;
   logic [NR-1:0]    req;
   logic [NR*8-1:0]  req_x;
   logic [NR*7-1:0]  req_y;
   logic [NR*3-1:0]  req_colour;
   logic [NR-1:0]    ack;
   logic             plot;
   logic [7:0]       plot_x;
   logic [6:0]       plot_y;
   logic [2:0]       plot_colour;
   logic             busy;
   logic             frame_overrun;

   sprite_draw_scheduler #(.NUM_REQ(NR), .SIZE(SZ), .BG_COLOUR(BG)) dut (
      .clock         (clock),
      .reset         (reset),
      .frame_tick    (frame_tick),
      .req           (req),
      .req_x         (req_x),
      .req_y         (req_y),
      .req_colour    (req_colour),
      .ack           (ack),
      .plot          (plot),
      .plot_x        (plot_x),
      .plot_y        (plot_y),
      .plot_colour   (plot_colour),
      .busy          (busy),
      .frame_overrun (frame_overrun)
   );

   typedef struct {
      bit is_ack;
      int cyc;
      int x;
      int y;
      int c;
      int a;
   } ev_t;

   ev_t sbq[$];
   ev_t mon_e;
   int  tests = 0;
   int  fails = 0;
   int  cyc   = 0;

   // Reference model state: requested positions and what the scheduler last drew.
   int  m_x [NR];
   int  m_y [NR];
   int  m_c [NR];
   int  m_px[NR];
   int  m_py[NR];
   bit  m_pv[NR];
   int  m_ptr;

   initial forever #5 clock = ~clock;
   initial forever begin
      @(posedge clock);
      cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_plot(input int c, input int x, input int y, input int col);
      ev_t e;
      e.is_ack = 1'b0; e.cyc = c; e.x = x % 256; e.y = y % 128; e.c = col; e.a = 0;
      sbq.push_back(e);
   endtask

   task automatic push_ack(input int c, input int a);
      ev_t e;
      e.is_ack = 1'b1; e.cyc = c; e.x = 0; e.y = 0; e.c = 0; e.a = a;
      sbq.push_back(e);
   endtask

   // Whole-frame model: tick at cycle t, SELECT at t+1, each service plots from the cycle after SELECT.
   task automatic model_frame(input int t, input logic [NR-1:0] r, output int idle_c, output int first_ack);
      logic [NR-1:0] pend;
      int b, c, j;
      pend = r;
      b = t + 1;
      first_ack = -1;
      while (pend != '0) begin
         j = -1;
         for (int k = 1; k <= NR; k++)
            if (j < 0 && pend[(m_ptr + k) % NR]) j = (m_ptr + k) % NR;
         c = b + 1;
         if (ERASE && m_pv[j])
            for (int p = 0; p < SZ*SZ; p++) begin
               push_plot(c, m_px[j] + p % SZ, m_py[j] + p / SZ, BG);
               c++;
            end
         for (int p = 0; p < SZ*SZ; p++) begin
            push_plot(c, m_x[j] + p % SZ, m_y[j] + p / SZ, m_c[j]);
            c++;
         end
         push_ack(c, j);
         if (first_ack < 0) first_ack = c;
         m_pv[j] = 1'b1; m_px[j] = m_x[j]; m_py[j] = m_y[j];
         pend[j] = 1'b0;
         m_ptr = j;
         b = c + 1;
      end
      idle_c = (r == '0) ? t + 1 : b + 1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_pv[i] = 1'b0;
      m_ptr = NR - 1;
   endtask

   task automatic set_inputs();
      for (int i = 0; i < NR; i++) begin
         req_x[i*8 +: 8]      = 8'(m_x[i]);
         req_y[i*7 +: 7]      = 7'(m_y[i]);
         req_colour[i*3 +: 3] = 3'(m_c[i]);
      end
   endtask

   // ov1/ov2: tick offsets from t to pulse while busy (-1 none, -2 random, -3 first ack cycle).
   task automatic do_frame(input logic [NR-1:0] r, input int ov1, input int ov2);
      int t, idle_c, first_ack, o1, o2;
      bit done;
      @(posedge clock); #1;
      req = r; frame_tick = 1'b1; t = cyc;
      model_frame(t, r, idle_c, first_ack);
      o1 = ov1; o2 = ov2;
      if (ov1 == -2) o1 = (idle_c - t > 2) ? int'($urandom_range(1, idle_c - t - 1)) : -1;
      if (ov2 == -3) o2 = first_ack - t;
      #1;
      check("overrun_idle", int'(frame_overrun), 0);
      done = 1'b0;
      for (int i = 0; i < 1000 && !done; i++) begin
         @(posedge clock); #1;
         req = '0;
         frame_tick = (o1 > 0 && cyc == t + o1) || (o2 > 0 && cyc == t + o2);
         #1;
         check("overrun", int'(frame_overrun), int'(frame_tick));
         if (!busy) begin
            done = 1'b1;
            check("idle_cycle", cyc, idle_c);
            check("drained", sbq.size(), 0);
         end
      end
      frame_tick = 1'b0;
      if (!done) check("idle_timeout", 0, 1);
   endtask

   task automatic reset_mid_draw();
      int t, idle_c, first_ack, tr;
      @(posedge clock); #1;
      m_x[0] = 30; m_y[0] = 40; m_c[0] = 4; set_inputs();
      req = 4'b0001; frame_tick = 1'b1; t = cyc;
      model_frame(t, 4'b0001, idle_c, first_ack);
      tr = first_ack - 6;
      @(posedge clock); #1;
      frame_tick = 1'b0; req = '0;
      for (int i = 0; i < 1000 && cyc < tr; i++) begin
         @(posedge clock); #1;
      end
      check("rst_reach", cyc, tr);
      reset = 1'b0;
      @(posedge clock); #1;
      check("rst_mid_plot", int'(plot), 0);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_ack", int'(ack), 0);
      sbq.delete();
      model_reset();
      reset = 1'b1;
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (plot || ack != '0) begin
            tests++;
            if (sbq.size() == 0) begin
               fails++;
               $display("FAIL unexpected_output: cycle %0d plot=%0b x=%0d y=%0d ack=%b", cyc, plot, plot_x, plot_y, ack);
            end else begin
               mon_e = sbq.pop_front();
               if (mon_e.is_ack) begin
                  if (plot || ack != NR'(1 << mon_e.a) || cyc != mon_e.cyc) begin
                     fails++;
                     $display("FAIL ack: got cycle %0d ack=%b plot=%0b, expected cycle %0d ack index %0d",
                              cyc, ack, plot, mon_e.cyc, mon_e.a);
                  end
               end else if (!plot || ack != '0 || cyc != mon_e.cyc || int'(plot_x) != mon_e.x ||
                            int'(plot_y) != mon_e.y || int'(plot_colour) != mon_e.c) begin
                  fails++;
                  $display("FAIL plot: got cycle %0d plot=%0b x=%0d y=%0d c=%0d ack=%b, expected cycle %0d x=%0d y=%0d c=%0d",
                           cyc, plot, plot_x, plot_y, plot_colour, ack, mon_e.cyc, mon_e.x, mon_e.y, mon_e.c);
               end
            end
         end
      end
   end

   initial begin
      logic [NR-1:0] rr;
      reset = 1'b0; frame_tick = 1'b0; req = '0;
      for (int i = 0; i < NR; i++) begin
         m_x[i] = 0; m_y[i] = 0; m_c[i] = 0; m_px[i] = 0; m_py[i] = 0;
      end
      model_reset();
      set_inputs();
      repeat (3) @(posedge clock);
      #1;
      check("rst_plot", int'(plot), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ack", int'(ack), 0);
      check("rst_overrun", int'(frame_overrun), 0);
      check("rst_plot_x", int'(plot_x), 0);
      check("rst_plot_y", int'(plot_y), 0);
      check("rst_plot_colour", int'(plot_colour), 0);
      reset = 1'b1;

      m_x[0] = 10; m_y[0] = 20; m_c[0] = 3; set_inputs();
      do_frame(4'b0001, -1, -1);
      m_x[0] = 11; set_inputs();
      do_frame(4'b0001, -1, -1);

      m_x[1] = 50;  m_y[1] = 60; m_c[1] = 5;
      m_x[2] = 100; m_y[2] = 30; m_c[2] = 6; set_inputs();
      do_frame(4'b0010, -1, -1);
      do_frame(4'b0101, -1, -1);

      do_frame(4'b0000, -1, -1);
      req = 4'b1111;
      repeat (5) begin
         @(posedge clock); #1;
         check("no_tick_busy", int'(busy), 0);
      end
      req = '0;

      m_x[3] = 200; m_y[3] = 5; m_c[3] = 7; set_inputs();
      do_frame(4'b1111, 5, -3);

      m_x[1] = 254; m_y[1] = 126; m_c[1] = 2; set_inputs();
      do_frame(4'b0010, -1, -1);

      reset_mid_draw();
      do_frame(4'b0001, -1, -1);

      repeat (25) begin
         for (int i = 0; i < NR; i++) begin
            m_x[i] = int'($urandom_range(0, 255));
            m_y[i] = int'($urandom_range(0, 127));
            m_c[i] = int'($urandom_range(0, 7));
         end
         set_inputs();
         rr = NR'($urandom_range(0, 15));
         do_frame(rr, -2, -1);
      end

      repeat (3) @(posedge clock);
      #1;
      check("final_queue_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
